// File: rtl/blit_pixel_stage_if.sv
// -----------------------------------------------------------------------------
// blit_pixel_stage_if
// Bundles the three streams around the blitter pixel stage:
//   coordinate in  : p1_x/p1_y/p1_src_x/p1_src_y/p1_bit_index/p1_valid, p2_ready back
//   byte read port : mem_rd_req/mem_rd_addr out, mem_rd_ack/mem_rd_valid/mem_rd_data in
//   write FIFO     : fifo_full in, wr_valid/wr_addr/wr_data out
// Modports: slave = the pixel stage, master = its surroundings (coordinate
// generator, memory, write FIFO).
// -----------------------------------------------------------------------------
interface blit_pixel_stage_if #(
  parameter int ADDR_W = 32
);
  logic [15:0]       p1_x;
  logic [15:0]       p1_y;
  logic [15:0]       p1_src_x;
  logic [15:0]       p1_src_y;
  logic [2:0]        p1_bit_index;
  logic              p1_valid;
  logic              p2_ready;

  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ack;
  logic              mem_rd_valid;
  logic [7:0]        mem_rd_data;

  logic              fifo_full;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output p1_x, p1_y, p1_src_x, p1_src_y, p1_bit_index, p1_valid,
    input  p2_ready,
    input  mem_rd_req, mem_rd_addr,
    output mem_rd_ack, mem_rd_valid, mem_rd_data,
    output fifo_full,
    input  wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  p1_x, p1_y, p1_src_x, p1_src_y, p1_bit_index, p1_valid,
    output p2_ready,
    output mem_rd_req, mem_rd_addr,
    input  mem_rd_ack, mem_rd_valid, mem_rd_data,
    input  fifo_full,
    output wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/blit_pixel_stage.sv
// -----------------------------------------------------------------------------
// blit_pixel_stage
// Stage 2 of the blitter: turns each coordinate from the coordinate generator
// into at most one 8bpp byte write. RECT writes reg_color, COPY reads the source
// byte and writes it back out, TEXT reads a font byte (through a one-entry cache)
// and writes fg/bg per bit. One pixel in flight; single outstanding read.
//
// Ports
//   clk_i, rst_ni       clock, synchronous active-low reset
//   start_i             new blit: invalidates the font cache
//   reg_command_i       1 = RECT, 2 = COPY, 3 = TEXT, others = drop pixel
//   reg_dest_base_i/_stride_i, reg_src_base_i/_stride_i   address generation
//   reg_color_i, reg_bg_color_i, reg_transparent_i         pixel colours
//   reg_clip_{x1,y1,x2,y2}_i   clip window [x1,x2) x [y1,y2)  (BLIT_CLIP_EN)
//   bus                 blit_pixel_stage_if.slave: coordinate in, read port,
//                       write FIFO port
//
// Configuration macro: BLIT_CLIP_EN adds the clip ports and drops pixels
// outside the window in CALC; undefined, every pixel is processed.
// -----------------------------------------------------------------------------
module blit_pixel_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [4:0]        reg_command_i,
  input  logic [ADDR_W-1:0] reg_dest_base_i,
  input  logic [15:0]       reg_dest_stride_i,
  input  logic [ADDR_W-1:0] reg_src_base_i,
  input  logic [15:0]       reg_src_stride_i,
  input  logic [7:0]        reg_color_i,
  input  logic [7:0]        reg_bg_color_i,
  input  logic              reg_transparent_i,
`ifdef BLIT_CLIP_EN
  input  logic [15:0]       reg_clip_x1_i,
  input  logic [15:0]       reg_clip_y1_i,
  input  logic [15:0]       reg_clip_x2_i,
  input  logic [15:0]       reg_clip_y2_i,
`endif
  blit_pixel_stage_if.slave bus
);

  localparam logic [4:0] BLIT_RECT = 5'd1;
  localparam logic [4:0] BLIT_COPY = 5'd2;
  localparam logic [4:0] BLIT_TEXT = 5'd3;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_READ, S_WAIT, S_WRITE} state_e;

  state_e            state_q, state_d;
  logic [15:0]       x_q, y_q, sx_q, sy_q;
  logic [2:0]        bit_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;     // 0: transparent pixel, WRITE just retires
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              cache_vld_q, cache_vld_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic [7:0]        cache_data_q, cache_data_d;

  logic              accept_c;
  logic              clipped_c;
  logic              cache_hit_c;
  logic [31:0]       dest_off_c, src_off_c;
  logic [ADDR_W-1:0] dest_addr_c, src_addr_c;

  // Returns {write_enable, pixel}; bit_index 0 selects the font byte MSB.
  function automatic logic [8:0] text_pix(input logic [7:0] font, input logic [2:0] idx,
                                          input logic [7:0] fg, input logic [7:0] bg,
                                          input logic transp);
    logic b;
    b = font[3'd7 - idx];
    return {b | ~transp, b ? fg : bg};
  endfunction

  assign accept_c = (state_q == S_IDLE) && bus.p1_valid;

  // Full 16x16 products, then wrap modulo 2^ADDR_W.
  assign dest_off_c  = {16'd0, y_q} * {16'd0, reg_dest_stride_i};
  assign src_off_c   = {16'd0, sy_q} * {16'd0, reg_src_stride_i};
  assign dest_addr_c = reg_dest_base_i + ADDR_W'(dest_off_c) + ADDR_W'(x_q);
  assign src_addr_c  = reg_src_base_i + ADDR_W'(src_off_c) + ADDR_W'(sx_q);

  assign cache_hit_c = cache_vld_q && (cache_addr_q == src_addr_c);

`ifdef BLIT_CLIP_EN
  assign clipped_c = (x_q < reg_clip_x1_i) || (x_q >= reg_clip_x2_i) ||
                     (y_q < reg_clip_y1_i) || (y_q >= reg_clip_y2_i);
`else
  assign clipped_c = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = wr_en_q;
    rd_addr_d    = rd_addr_q;
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
    cache_data_d = cache_data_q;
    case (state_q)
      S_IDLE: if (bus.p1_valid) state_d = S_CALC;
      S_CALC: begin
        wr_addr_d = dest_addr_c;
        rd_addr_d = src_addr_c;
        wr_en_d   = 1'b1;
        if (clipped_c) begin
          state_d = S_IDLE;
        end else begin
          case (reg_command_i)
            BLIT_RECT: begin
              wr_data_d = reg_color_i;
              state_d   = S_WRITE;
            end
            BLIT_COPY: state_d = S_READ;
            BLIT_TEXT: begin
              if (cache_hit_c) begin
                {wr_en_d, wr_data_d} = text_pix(cache_data_q, bit_q, reg_color_i,
                                                reg_bg_color_i, reg_transparent_i);
                state_d = S_WRITE;
              end else begin
                state_d = S_READ;
              end
            end
            default: state_d = S_IDLE;  // unknown command: consume silently
          endcase
        end
      end
      S_READ: if (bus.mem_rd_ack) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_rd_valid) begin
          state_d = S_WRITE;
          if (reg_command_i == BLIT_TEXT) begin
            {wr_en_d, wr_data_d} = text_pix(bus.mem_rd_data, bit_q, reg_color_i,
                                            reg_bg_color_i, reg_transparent_i);
            cache_vld_d  = 1'b1;
            cache_addr_d = rd_addr_q;
            cache_data_d = bus.mem_rd_data;
          end else begin
            wr_data_d = bus.mem_rd_data;
          end
        end
      end
      S_WRITE: if (!wr_en_q || !bus.fifo_full) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A new blit may point the font base elsewhere; a fill landing on the
    // same edge must not survive.
    if (start_i) cache_vld_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      bit_q        <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      rd_addr_q    <= rd_addr_d;
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
      if (accept_c) begin
        x_q   <= bus.p1_x;
        y_q   <= bus.p1_y;
        sx_q  <= bus.p1_src_x;
        sy_q  <= bus.p1_src_y;
        bit_q <= bus.p1_bit_index;
      end
    end
  end

  assign bus.p2_ready    = (state_q == S_IDLE);
  assign bus.mem_rd_req  = (state_q == S_READ);
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.wr_valid    = (state_q == S_WRITE) && wr_en_q && !bus.fifo_full;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;

endmodule

// File: tb/tb_blit_pixel_stage.sv
// Directed bench for blit_pixel_stage: a table of pixel records with
// hand-computed addresses, data, read counts and cycle timings, plus
// hand-written sequences for FIFO back-pressure, clipping and reset in WAIT.
module tb_blit_pixel_stage;
  localparam logic [4:0] RECT = 5'd1;
  localparam logic [4:0] COPY = 5'd2;
  localparam logic [4:0] TEXT = 5'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  reg_command = '0;
  logic [31:0] reg_dest_base = '0;
  logic [15:0] reg_dest_stride = '0;
  logic [31:0] reg_src_base = 32'h2000;
  logic [15:0] reg_src_stride = 16'd320;
  logic [7:0]  reg_color = '0;
  logic [7:0]  reg_bg_color = '0;
  logic        reg_transparent = 1'b0;
`ifdef BLIT_CLIP_EN
  logic [15:0] clip_x1 = 16'd0, clip_y1 = 16'd0, clip_x2 = 16'hFFFF, clip_y2 = 16'hFFFF;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int wr_full_viol = 0;

  always #5 clk = ~clk;

  blit_pixel_stage_if #(.ADDR_W(32)) bus ();

  blit_pixel_stage #(.ADDR_W(32)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .start_i           (start),
    .reg_command_i     (reg_command),
    .reg_dest_base_i   (reg_dest_base),
    .reg_dest_stride_i (reg_dest_stride),
    .reg_src_base_i    (reg_src_base),
    .reg_src_stride_i  (reg_src_stride),
    .reg_color_i       (reg_color),
    .reg_bg_color_i    (reg_bg_color),
    .reg_transparent_i (reg_transparent),
`ifdef BLIT_CLIP_EN
    .reg_clip_x1_i     (clip_x1),
    .reg_clip_y1_i     (clip_y1),
    .reg_clip_x2_i     (clip_x2),
    .reg_clip_y2_i     (clip_y2),
`endif
    .bus               (bus)
  );

  // Fields: command/regs, coordinate, byte the memory returns, then expected
  // read count/addr, write count, last write addr/data, cycle of first
  // wr_valid and of p2_ready after accept (accept cycle = 0).
  typedef struct {
    logic [4:0]  cmd;
    logic [31:0] dbase;
    logic [15:0] dstride;
    logic [7:0]  color;
    logic [7:0]  bg;
    logic        transp;
    logic        start;
    logic [15:0] x, y, sx, sy;
    logic [2:0]  bi;
    logic [7:0]  rdata;
    int          e_nrd;
    logic [31:0] e_rda;
    int          e_nwr;
    logic [31:0] e_wa;
    logic [7:0]  e_wd;
    int          e_wlat;
    int          e_idle;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Drives one coordinate, acts as the memory (ack next cycle, data two
  // cycles later) and watches the write port until the stage is idle again.
  task automatic run_pixel(input vec_t v, input int full_until, input int rst_cyc, input string nm);
    int nrd, nwr, wlat, idle, phase, dly, c;
    logic [31:0] rda, wa;
    logic [7:0]  wd;
    nrd = 0; nwr = 0; wlat = -1; idle = -1; phase = 0; dly = 0;
    rda = '0; wa = '0; wd = '0;
    @(negedge clk);
    reg_command = v.cmd; reg_dest_base = v.dbase; reg_dest_stride = v.dstride;
    reg_color = v.color; reg_bg_color = v.bg; reg_transparent = v.transp;
    if (v.start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    bus.p1_x = v.x; bus.p1_y = v.y; bus.p1_src_x = v.sx; bus.p1_src_y = v.sy;
    bus.p1_bit_index = v.bi; bus.p1_valid = 1'b1;
    c = 0;
    while (!bus.p2_ready && c < 10) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    bus.p1_valid = 1'b0;
    for (c = 1; c <= 40; c++) begin
      bus.fifo_full = (c < full_until);
      rst_n = (c != rst_cyc);
      #1;
      if (bus.wr_valid) begin
        if (bus.fifo_full) wr_full_viol++;
        nwr++;
        wa = bus.wr_addr;
        wd = bus.wr_data;
        if (wlat < 0) wlat = c;
      end
      if (bus.p2_ready && phase == 0) begin
        idle = c;
        break;
      end
      case (phase)
        0: if (bus.mem_rd_req) begin
          nrd++;
          rda = bus.mem_rd_addr;
          bus.mem_rd_ack = 1'b1;
          phase = 1;
          dly = 1;
        end
        1: begin
          bus.mem_rd_ack = 1'b0;
          if (dly == 0) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data = v.rdata;
            phase = 2;
          end else begin
            dly--;
          end
        end
        default: begin
          bus.mem_rd_valid = 1'b0;
          phase = 0;
        end
      endcase
      @(negedge clk);
    end
    bus.fifo_full = 1'b0;
    rst_n = 1'b1;
    bus.mem_rd_ack = 1'b0;
    bus.mem_rd_valid = 1'b0;
    chk($sformatf("%s reads", nm), nrd, v.e_nrd);
    if (v.e_nrd > 0) chk($sformatf("%s rd_addr", nm), rda, v.e_rda);
    chk($sformatf("%s writes", nm), nwr, v.e_nwr);
    if (v.e_nwr > 0) begin
      chk($sformatf("%s wr_addr", nm), wa, v.e_wa);
      chk($sformatf("%s wr_data", nm), {24'd0, wd}, {24'd0, v.e_wd});
      chk($sformatf("%s wr latency", nm), wlat, v.e_wlat);
    end
    chk($sformatf("%s ready cycle", nm), idle, v.e_idle);
  endtask

  vec_t vt[4];
  vec_t v;
  logic [7:0] opaque_exp[8];
  int         bit_set[8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.p1_x = '0; bus.p1_y = '0; bus.p1_src_x = '0; bus.p1_src_y = '0;
    bus.p1_bit_index = '0; bus.p1_valid = 1'b0;
    bus.mem_rd_ack = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
    bus.fifo_full = 1'b0;

    // font byte 0xA5, MSB first: 1 0 1 0 0 1 0 1
    opaque_exp = '{8'h0F, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h0F};
    bit_set    = '{1, 0, 1, 0, 0, 1, 0, 1};

    //          cmd   dbase         dstride     color  bg    tr    st    x          y          sx      sy     bi    rdata  nrd rda           nwr wa            wd     wlat idle
    vt[0] = '{RECT, 32'h1000,     16'd640,    8'h5A, 8'h00, 1'b0, 1'b0, 16'd2,     16'd3,     16'd0,  16'd0, 3'd0, 8'h00, 0,  32'h0,        1,  32'h1782,     8'h5A, 2,   3};
    vt[1] = '{COPY, 32'h1000,     16'd640,    8'h5A, 8'h00, 1'b0, 1'b0, 16'd5,     16'd0,     16'd10, 16'd1, 3'd0, 8'h77, 1,  32'h214A,     1,  32'h1005,     8'h77, 5,   6};
    vt[2] = '{RECT, 32'hFFFFFF00, 16'hFFFF,   8'hC3, 8'h00, 1'b0, 1'b0, 16'hFFFE,  16'hFFFE,  16'd0,  16'd0, 3'd0, 8'h00, 0,  32'h0,        1,  32'hFFFDFF00, 8'hC3, 2,   3};
    vt[3] = '{5'd7, 32'h1000,     16'd640,    8'h5A, 8'h00, 1'b0, 1'b0, 16'd1,     16'd1,     16'd3,  16'd3, 3'd0, 8'h00, 0,  32'h0,        0,  32'h0,        8'h00, 0,   2};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset p2_ready", {31'd0, bus.p2_ready}, 32'd1);
    chk("reset mem_rd_req", {31'd0, bus.mem_rd_req}, 32'd0);
    chk("reset wr_valid", {31'd0, bus.wr_valid}, 32'd0);
    chk("reset wr_addr", bus.wr_addr, 32'd0);
    chk("reset wr_data", {24'd0, bus.wr_data}, 32'd0);
    chk("reset mem_rd_addr", bus.mem_rd_addr, 32'd0);

    for (int i = 0; i < 4; i++) run_pixel(vt[i], 0, -1, $sformatf("vec%0d", i));

    // TEXT, opaque: one fetch of 0x2000+5*320+2, then cache hits
    for (int i = 0; i < 8; i++) begin
      v = '{TEXT, 32'h1000, 16'd640, 8'h0F, 8'h00, 1'b0, 1'b0, 16'(10 + i), 16'd4, 16'd2, 16'd5,
            3'(i), 8'hA5, (i == 0) ? 1 : 0, 32'h2642, 1, 32'h1A0A + i, opaque_exp[i],
            (i == 0) ? 5 : 2, (i == 0) ? 6 : 3};
      run_pixel(v, 0, -1, $sformatf("text_opq%0d", i));
    end
    // TEXT, transparent: cached, only the four set bits write
    for (int i = 0; i < 8; i++) begin
      v = '{TEXT, 32'h1000, 16'd640, 8'h0F, 8'h00, 1'b1, 1'b0, 16'(10 + i), 16'd6, 16'd2, 16'd5,
            3'(i), 8'hA5, 0, 32'h0, bit_set[i], 32'h1F0A + i, 8'h0F, 2, 3};
      run_pixel(v, 0, -1, $sformatf("text_trn%0d", i));
    end
    // start invalidates the cache: same font byte is fetched again
    v = '{TEXT, 32'h1000, 16'd640, 8'h0F, 8'h00, 1'b0, 1'b1, 16'd30, 16'd4, 16'd2, 16'd5,
          3'd0, 8'hA5, 1, 32'h2642, 1, 32'h1A1E, 8'h0F, 5, 6};
    run_pixel(v, 0, -1, "text_restart");

    // FIFO full for the first 5 WRITE cycles: one write at cycle 7
    v = '{RECT, 32'h1000, 16'd640, 8'h5A, 8'h00, 1'b0, 1'b0, 16'd0, 16'd1, 16'd0, 16'd0,
          3'd0, 8'h00, 0, 32'h0, 1, 32'h1280, 8'h5A, 7, 8};
    run_pixel(v, 7, -1, "fifo_stall");

`ifdef BLIT_CLIP_EN
    clip_x2 = 16'd100;
    v = '{COPY, 32'h1000, 16'd640, 8'h5A, 8'h00, 1'b0, 1'b0, 16'd100, 16'd0, 16'd0, 16'd0,
          3'd0, 8'h11, 0, 32'h0, 0, 32'h0, 8'h00, 0, 2};
    run_pixel(v, 0, -1, "clip_out");
    v = '{RECT, 32'h1000, 16'd640, 8'h5A, 8'h00, 1'b0, 1'b0, 16'd99, 16'd0, 16'd0, 16'd0,
          3'd0, 8'h00, 0, 32'h0, 1, 32'h1063, 8'h5A, 2, 3};
    run_pixel(v, 0, -1, "clip_in");
    clip_x2 = 16'hFFFF;
`endif

    // reset while waiting for read data: late data ignored, cache dropped
    v = '{COPY, 32'h1000, 16'd640, 8'h5A, 8'h00, 1'b0, 1'b0, 16'd1, 16'd0, 16'd0, 16'd0,
          3'd0, 8'h99, 1, 32'h2000, 0, 32'h0, 8'h00, 0, 6};
    run_pixel(v, 0, 3, "rst_in_wait");
    v = '{TEXT, 32'h1000, 16'd640, 8'h0F, 8'h00, 1'b0, 1'b0, 16'd40, 16'd4, 16'd2, 16'd5,
          3'd1, 8'hA5, 1, 32'h2642, 1, 32'h1A28, 8'h00, 5, 6};
    run_pixel(v, 0, -1, "text_after_rst");

    chk("no write while fifo_full", wr_full_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
